// File: rtl/counter_arbiter.sv
// counter_arbiter
//   Shares one interval counter between NREQ requesters. A requester holds
//   req[i] high; the block arbitrates in IDLE, runs the count in RUN
//   (count 0..target, where target is the winner's load_val slice latched at
//   grant time), then pulses done[winner] for one cycle in DONE. Dropping
//   req[winner] during RUN aborts the count with no done pulse.
//
//   Arbitration is round robin by default. Defining COUNTER_ARB_FIXED_PRIO_EN
//   builds fixed priority instead (lowest asserted index wins, no pointer).
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   req       in   [NREQ]        level request per requester
//   load_val  in   [NREQ*WIDTH]  interval per requester, slice i at [i*WIDTH +: WIDTH]
//   gnt       out  [NREQ]        one-hot grant, high during RUN
//   active    out                counter enable, high during RUN
//   count     out  [WIDTH]       current count value
//   done      out  [NREQ]        one-cycle completion pulse to the winner
//   busy      out                high whenever not IDLE
//
// Every output comes straight from a register; there is no combinational
// path from req or load_val to any output.

module counter_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   load_val,
    output logic [NREQ-1:0]         gnt,
    output logic                    active,
    output logic [WIDTH-1:0]        count,
    output logic [NREQ-1:0]         done,
    output logic                    busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [NREQ-1:0]    r_gnt;
    logic [NREQ-1:0]    r_done;
    logic               r_active;
    logic               r_busy;
    logic [WIDTH-1:0]   r_count;
    logic [WIDTH-1:0]   r_target;

    logic [IW-1:0]      w_win;
    logic [WIDTH-1:0]   w_load;
    logic               w_start;
    logic               w_hold;

    function automatic logic [NREQ-1:0] f_onehot(input logic [IW-1:0] idx);
        logic [NREQ-1:0] oh;
        oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            oh[i] = (idx == IW'(i));
        end
        return oh;
    endfunction

`ifdef COUNTER_ARB_FIXED_PRIO_EN
    function automatic logic [IW-1:0] f_fixed_pick(input logic [NREQ-1:0] rq);
        logic [IW-1:0] pick;
        pick = '0;
        // Scan downwards so the lowest asserted index is written last.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rq[i]) pick = IW'(i);
        end
        return pick;
    endfunction

    assign w_win = f_fixed_pick(req);
`else
    logic [IW-1:0] r_ptr;

    function automatic logic [IW-1:0] f_rr_pick(input logic [NREQ-1:0] rq,
                                                input logic [IW-1:0]   ptr);
        logic [2*NREQ-1:0] dbl;
        logic [IW-1:0]     off;
        logic [IW:0]       sum;
        // Rotate so the pointer position lands at bit 0, then find the
        // first set bit and map the offset back to an absolute index.
        dbl = {rq, rq} >> ptr;
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (dbl[i]) off = IW'(i);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
        return sum[IW-1:0];
    endfunction

    function automatic logic [IW-1:0] f_next_idx(input logic [IW-1:0] idx);
        return (idx == IW'(NREQ - 1)) ? '0 : idx + IW'(1);
    endfunction

    assign w_win = f_rr_pick(req, r_ptr);

    // Pointer moves past the winner on every grant, including grants that
    // are later aborted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_start) begin
            r_ptr <= f_next_idx(w_win);
        end
    end
`endif

    always_comb begin
        w_load = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == IW'(i)) w_load = load_val[i*WIDTH +: WIDTH];
        end
    end

    assign w_start = (r_state == S_IDLE) && (|req);
    // r_gnt is the one-hot winner during RUN, so this is req[winner].
    assign w_hold  = |(req & r_gnt);

    // Target is pure data: captured only on the IDLE->RUN edge, no reset.
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_target <= w_load;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_gnt    <= '0;
            r_done   <= '0;
            r_active <= 1'b0;
            r_busy   <= 1'b0;
            r_count  <= '0;
        end else begin
            r_done <= '0;
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_state  <= S_RUN;
                        r_gnt    <= f_onehot(w_win);
                        r_active <= 1'b1;
                        r_busy   <= 1'b1;
                        r_count  <= '0;
                    end
                end
                S_RUN: begin
                    if (!w_hold) begin
                        // Abort: count holds, no done pulse.
                        r_state  <= S_IDLE;
                        r_gnt    <= '0;
                        r_active <= 1'b0;
                        r_busy   <= 1'b0;
                    end else if (r_count == r_target) begin
                        r_state  <= S_DONE;
                        r_done   <= r_gnt;
                        r_gnt    <= '0;
                        r_active <= 1'b0;
                    end else begin
                        r_count <= r_count + WIDTH'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_gnt    <= '0;
                    r_active <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign gnt    = r_gnt;
    assign active = r_active;
    assign count  = r_count;
    assign done   = r_done;
    assign busy   = r_busy;

endmodule

// File: tb/tb_counter_arbiter.sv
module tb_counter_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] load_val;
    logic [3:0]  gnt;
    logic        active;
    logic [7:0]  count;
    logic [3:0]  done;
    logic        busy;

    typedef struct {
        logic [3:0] vec;
        logic [7:0] cnt;
        int         cyc;
    } done_t;

    logic [3:0] gq[$];
    done_t      dq[$];
    logic [3:0] prev_gnt;
    int         total;
    int         bad;
    int         cyc;

    counter_arbiter #(.NREQ(4), .WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .load_val (load_val),
        .gnt      (gnt),
        .active   (active),
        .count    (count),
        .done     (done),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    function automatic logic [3:0] oh(input int i);
        logic [3:0] one;
        one = 4'b0001;
        return one << i;
    endfunction

    // One clock; observe 1 time unit after the edge and run the scoreboard.
    task automatic tick();
        done_t      d;
        logic [3:0] g;
        @(posedge clk);
        cyc++;
        #1;
        if (gnt != 4'b0 && prev_gnt == 4'b0) begin
            if (gq.size() == 0) begin
                chk_eq("gnt_unexpected", 32'(gnt), 32'(0));
            end else begin
                g = gq.pop_front();
                chk_eq("gnt_order", 32'(gnt), 32'(g));
            end
        end
        prev_gnt = gnt;
        if (done != 4'b0) begin
            if (dq.size() == 0) begin
                chk_eq("done_unexpected", 32'(done), 32'(0));
            end else begin
                d = dq.pop_front();
                chk_eq("done_vec", 32'(done), 32'(d.vec));
                chk_eq("done_cyc", 32'(cyc), 32'(d.cyc));
                chk_eq("done_count", 32'(count), 32'(d.cnt));
            end
        end
    endtask

    // Request from an idle DUT; grant and completion are queued.
    task automatic issue(input int idx, input int lv);
        done_t d;
        chk_eq("issue_idle", 32'(busy), 32'(0));
        load_val[idx*8 +: 8] = lv[7:0];
        req = req | oh(idx);
        d.vec = oh(idx);
        d.cnt = lv[7:0];
        d.cyc = cyc + 2 + lv;
        gq.push_back(oh(idx));
        dq.push_back(d);
    endtask

    initial begin
        int         ord[$];
        int         c;
        done_t      d;
        logic [3:0] w;

        total    = 0;
        bad      = 0;
        cyc      = 0;
        prev_gnt = 4'b0;
        rst_n    = 1'b0;
        req      = 4'b1111;
        load_val = 32'h0;

        // Reset held with all requests pending
        repeat (3) tick();
        chk_eq("rst_gnt",    32'(gnt),    32'(0));
        chk_eq("rst_active", 32'(active), 32'(0));
        chk_eq("rst_count",  32'(count),  32'(0));
        chk_eq("rst_done",   32'(done),   32'(0));
        chk_eq("rst_busy",   32'(busy),   32'(0));
        rst_n = 1'b1;
        gq.push_back(4'b0001);
        d.vec = 4'b0001; d.cnt = 8'd0; d.cyc = cyc + 2;
        dq.push_back(d);
        tick();
        chk_eq("rel_gnt", 32'(gnt), 32'(4'b0001));
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();

        // Single request, interval 3; load_val change mid-run is ignored
        issue(2, 3);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_eq("single_gnt",   32'(gnt),   32'(4'b0100));
            chk_eq("single_count", 32'(count), 32'(k));
            if (k == 0) load_val[23:16] = 8'd9;
        end
        tick();
        chk_eq("single_done",   32'(done),   32'(4'b0100));
        chk_eq("single_gnt_lo", 32'(gnt),    32'(0));
        chk_eq("single_act_lo", 32'(active), 32'(0));
        req = 4'b0000;
        tick();
        chk_eq("single_busy_lo", 32'(busy), 32'(0));

        // Boundary intervals
        issue(3, 0);
        tick();
        chk_eq("lv0_gnt", 32'(gnt), 32'(4'b1000));
        tick();
        req = 4'b0000;
        tick();
        issue(0, 255);
        repeat (256) tick();
        chk_eq("lv255_count", 32'(count), 32'(255));
        chk_eq("lv255_gnt",   32'(gnt),   32'(4'b0001));
        tick();
        req = 4'b0000;
        tick();

        // Abort at count 5
        chk_eq("abort_pre_idle", 32'(busy), 32'(0));
        load_val[15:8] = 8'd20;
        req = 4'b0010;
        gq.push_back(4'b0010);
        repeat (6) tick();
        chk_eq("abort_count5", 32'(count), 32'(5));
        load_val[7:0]   = 8'd1;
        load_val[23:16] = 8'd1;
        req = 4'b0101;
`ifdef COUNTER_ARB_FIXED_PRIO_EN
        w = 4'b0001;
`else
        w = 4'b0100;
`endif
        gq.push_back(w);
        d.vec = w; d.cnt = 8'd1; d.cyc = cyc + 1 + 3;
        dq.push_back(d);
        tick();
        chk_eq("abort_gnt",   32'(gnt),   32'(0));
        chk_eq("abort_busy",  32'(busy),  32'(0));
        chk_eq("abort_count", 32'(count), 32'(5));
        chk_eq("abort_done",  32'(done),  32'(0));
        repeat (3) tick();
        req = 4'b0000;
        tick();

        // Asynchronous reset in the middle of a run
        chk_eq("mid_pre_idle", 32'(busy), 32'(0));
        load_val[15:8] = 8'd50;
        req = 4'b0010;
        gq.push_back(4'b0010);
        repeat (11) tick();
        chk_eq("mid_count10", 32'(count), 32'(10));
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("mid_gnt",    32'(gnt),    32'(0));
        chk_eq("mid_active", 32'(active), 32'(0));
        chk_eq("mid_count",  32'(count),  32'(0));
        chk_eq("mid_done",   32'(done),   32'(0));
        chk_eq("mid_busy",   32'(busy),   32'(0));
        req = 4'b0000;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Contention with requests held continuously, all intervals 0
`ifdef COUNTER_ARB_FIXED_PRIO_EN
        ord = '{0, 0, 0};
`else
        ord = '{0, 1, 3, 0, 1, 3};
`endif
        load_val = 32'h0;
        req = 4'b1011;
        c = cyc;
        for (int j = 0; j < ord.size(); j++) begin
            gq.push_back(oh(ord[j]));
            d.vec = oh(ord[j]); d.cnt = 8'd0; d.cyc = c + 2 + 3 * j;
            dq.push_back(d);
        end
        repeat (3 * ord.size() - 1) tick();
        req = 4'b0000;
        repeat (2) tick();
        chk_eq("cont_busy_lo", 32'(busy), 32'(0));

        chk_eq("sb_gnt_left",  32'(gq.size()), 32'(0));
        chk_eq("sb_done_left", 32'(dq.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
